ad9253_align_ctrl: RTL and testbench

Word-alignment training controller for the AD9253 receive path. It drives the `slip` input of the per-lane bitslip aligner. It watches the aligned frame-clock word coming back from that aligner and issues single-cycle slip pulses until the word matches the training pattern for a required number of consecutive cycles. Once aligned, it holds `locked` and automatically retrains when lock is lost.

---
 rtl/ad9253_pkg.sv | 17 +
 rtl/ad9253_align_ctrl_if.sv | 21 ++
 rtl/ad9253_align_ctrl.sv | 136 +++++++++++++
 tb/tb_ad9253_align_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ad9253_pkg.sv
// rtl/ad9253_pkg.sv - shared types and constants for the AD9253 lane alignment logic
package ad9253_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CHECK,
        ST_SLIP,
        ST_LOCKED,
        ST_FAIL
    } align_state_e;

    localparam logic [7:0] TRAIN_PATTERN_DEF = 8'hF0;
    // Bitslip aligner needs this many cycles before a slip shows up on its output.
    localparam int ALIGNER_LATENCY = 2;

endpackage

// File: rtl/ad9253_align_ctrl_if.sv
// rtl/ad9253_align_ctrl_if.sv - control/data bundle between the lane wrapper and the align controller
interface ad9253_align_ctrl_if #(
    parameter int DATA_WD = 8
);
    logic               start;
    logic [DATA_WD-1:0] frame_data;
    logic               slip;
    logic               locked;
    logic               align_err;
    logic [5:0]         slip_pos;

    modport master (
        output start, frame_data,
        input  slip, locked, align_err, slip_pos
    );

    modport slave (
        input  start, frame_data,
        output slip, locked, align_err, slip_pos
    );
endinterface

// File: rtl/ad9253_align_ctrl.sv
// rtl/ad9253_align_ctrl.sv - word-alignment training FSM driving the per-lane bitslip aligner
module ad9253_align_ctrl
    import ad9253_pkg::*;
#(
    parameter int                 DATA_WD       = 8,
    parameter logic [DATA_WD-1:0] TRAIN_PATTERN = DATA_WD'(TRAIN_PATTERN_DEF),
    parameter int                 SETTLE_CYC    = 4,
    parameter int                 MATCH_CNT     = 16,
    parameter int                 LOSS_THR      = 4,
    parameter int                 MAX_SLIP      = 2 * DATA_WD
) (
    input  logic              clk,
    input  logic              rst_n,
    ad9253_align_ctrl_if.slave bus
);

    localparam int         SETTLE_EFF = (SETTLE_CYC < ALIGNER_LATENCY) ? ALIGNER_LATENCY : SETTLE_CYC;
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_EFF - 1);
    localparam logic [7:0] MATCH_LIM   = 8'(MATCH_CNT);
    localparam logic [7:0] LOSS_LIM    = 8'(LOSS_THR);
    localparam logic [7:0] SLIP_LIM    = 8'(MAX_SLIP);
    localparam logic [5:0] POS_LAST    = 6'(DATA_WD - 1);

    align_state_e state_q, state_d;
    logic [7:0]   match_q, match_d;
    logic [7:0]   miss_q, miss_d;
    logic [7:0]   attempt_q, attempt_d;
    logic [7:0]   settle_q, settle_d;
    logic         slip_q, slip_d;
    logic         locked_q, locked_d;
    logic         err_q, err_d;
    logic [5:0]   pos_q, pos_d;
    logic         hit;

    assign hit = (bus.frame_data == TRAIN_PATTERN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            match_q   <= '0;
            miss_q    <= '0;
            attempt_q <= '0;
            settle_q  <= '0;
            slip_q    <= 1'b0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            pos_q     <= '0;
        end else begin
            state_q   <= state_d;
            match_q   <= match_d;
            miss_q    <= miss_d;
            attempt_q <= attempt_d;
            settle_q  <= settle_d;
            slip_q    <= slip_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
            pos_q     <= pos_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        match_d   = match_q;
        miss_d    = miss_q;
        attempt_d = attempt_q;
        settle_d  = settle_q;
        // Outputs follow the registered state, so each lags its state by one edge.
        slip_d    = (state_q == ST_SLIP);
        locked_d  = (state_q == ST_LOCKED);
        err_d     = err_q | (state_q == ST_FAIL);
        pos_d     = pos_q;
        if (state_q == ST_SLIP) begin
            pos_d = (pos_q == POS_LAST) ? 6'd0 : pos_q + 6'd1;
        end

        unique case (state_q)
            ST_IDLE: ;
            ST_WAIT: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    state_d  = ST_CHECK;
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end
            ST_CHECK: begin
                if (hit) begin
                    match_d = match_q + 8'd1;
                    if (match_q + 8'd1 == MATCH_LIM) begin
                        miss_d  = '0;
                        state_d = ST_LOCKED;
                    end
                end else begin
                    match_d = '0;
                    state_d = (attempt_q == SLIP_LIM) ? ST_FAIL : ST_SLIP;
                end
            end
            ST_SLIP: begin
                attempt_d = attempt_q + 8'd1;
                settle_d  = '0;
                state_d   = ST_WAIT;
            end
            ST_LOCKED: begin
                if (hit) begin
                    miss_d = '0;
                end else if (miss_q + 8'd1 == LOSS_LIM) begin
                    // Re-verify the current position before slipping away from it.
                    miss_d    = '0;
                    match_d   = '0;
                    attempt_d = '0;
                    state_d   = ST_CHECK;
                end else begin
                    miss_d = miss_q + 8'd1;
                end
            end
            ST_FAIL: ;
            default: state_d = ST_IDLE;
        endcase

        if (bus.start) begin
            state_d   = ST_WAIT;
            match_d   = '0;
            miss_d    = '0;
            attempt_d = '0;
            settle_d  = '0;
            locked_d  = 1'b0;
            err_d     = 1'b0;
        end
    end

    assign bus.slip      = slip_q;
    assign bus.locked    = locked_q;
    assign bus.align_err = err_q;
    assign bus.slip_pos  = pos_q;

endmodule

// File: tb/tb_ad9253_align_ctrl.sv
// tb/tb_ad9253_align_ctrl.sv - directed bench for ad9253_align_ctrl with a bitslip model in the loop
module tb_ad9253_align_ctrl;
    import ad9253_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic force_bad;
    int   rot;
    int   n_vec = 0;
    int   n_err = 0;

    ad9253_align_ctrl_if #(.DATA_WD(8)) bus ();

    ad9253_align_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
        logic [15:0] t;
        t = {v, v} << (k & 7);
        return t[15:8];
    endfunction

    // Bitslip aligner model: shift counter, then one output register stage.
    logic [2:0] shift_q;
    logic [7:0] align_q;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            align_q <= rotl8(8'hF0, rot);
        end else begin
            if (bus.slip) shift_q <= shift_q + 3'd1;
            align_q <= rotl8(8'hF0, rot + int'(shift_q));
        end
    end
    assign bus.frame_data = force_bad ? 8'h00 : align_q;

    int cyc = 0;
    int n_slip = 0;
    int last_slip = -1000;
    int min_gap = 1000;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.slip) begin
            n_slip    <= n_slip + 1;
            last_slip <= cyc;
            if (cyc - last_slip < min_gap) min_gap <= cyc - last_slip;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk) rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_locked(input string tag, input int budget);
        int n = 0;
        while (!bus.locked && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(bus.locked), 32'd1);
    endtask

    initial begin
        int base;
        int n;
        rst_n     = 1'b0;
        force_bad = 1'b0;
        rot       = 0;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_slip", 32'(bus.slip), 32'd0);
        chk("rst_locked", 32'(bus.locked), 32'd0);
        chk("rst_err", 32'(bus.align_err), 32'd0);
        chk("rst_pos", 32'(bus.slip_pos), 32'd0);
        rst_n = 1'b1;

        // Already aligned: lock at edge 21, no slips.
        base = n_slip;
        pulse_start();
        repeat (20) @(negedge clk);
        chk("rot0_locked_e20", 32'(bus.locked), 32'd0);
        @(negedge clk);
        chk("rot0_locked_e21", 32'(bus.locked), 32'd1);
        chk("rot0_slips", 32'(n_slip - base), 32'd0);
        chk("rot0_pos", 32'(bus.slip_pos), 32'd0);

        // 3 misses, 1 hit, 3 misses keeps lock; 4 misses drops it.
        base = n_slip;
        force_bad = 1'b1; repeat (3) @(negedge clk);
        force_bad = 1'b0; @(negedge clk);
        force_bad = 1'b1; repeat (3) @(negedge clk);
        force_bad = 1'b0; @(negedge clk);
        chk("loss_held", 32'(bus.locked), 32'd1);
        force_bad = 1'b1; repeat (4) @(negedge clk);
        force_bad = 1'b0;
        chk("loss_edge_of_4th", 32'(bus.locked), 32'd1);
        @(negedge clk);
        chk("loss_dropped", 32'(bus.locked), 32'd0);
        wait_locked("loss_relock", 100);
        chk("loss_no_slip", 32'(n_slip - base), 32'd0);

        // Five slips needed.
        rot = 3;
        do_reset();
        base = n_slip;
        pulse_start();
        wait_locked("rot5_lock", 300);
        chk("rot5_slips", 32'(n_slip - base), 32'd5);
        chk("rot5_gap_ok", 32'(min_gap >= 5), 32'd1);
        chk("rot5_pos", 32'(bus.slip_pos), 32'd5);

        // Never matches: 16 slips then failure.
        force_bad = 1'b1;
        do_reset();
        base = n_slip;
        pulse_start();
        n = 0;
        while (!bus.align_err && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("fail_err", 32'(bus.align_err), 32'd1);
        chk("fail_slips", 32'(n_slip - base), 32'd16);
        chk("fail_locked", 32'(bus.locked), 32'd0);
        chk("fail_pos", 32'(bus.slip_pos), 32'd0);
        repeat (3) @(negedge clk);
        chk("fail_sticky", 32'(bus.align_err), 32'd1);
        force_bad = 1'b0;

        // Restart in WAIT after the 3rd slip.
        rot = 3;
        do_reset();
        base = n_slip;
        pulse_start();
        n = 0;
        while (n_slip - base < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("mid_three_slips", 32'(n_slip - base), 32'd3);
        pulse_start();
        chk("mid_pos_kept", 32'(bus.slip_pos), 32'd3);
        chk("mid_err", 32'(bus.align_err), 32'd0);
        wait_locked("mid_lock", 300);
        chk("mid_slips", 32'(n_slip - base), 32'd5);
        chk("mid_pos", 32'(bus.slip_pos), 32'd5);

        // Asynchronous reset while locked.
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("arst_locked", 32'(bus.locked), 32'd0);
        chk("arst_slip", 32'(bus.slip), 32'd0);
        chk("arst_err", 32'(bus.align_err), 32'd0);
        chk("arst_pos", 32'(bus.slip_pos), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base = n_slip;
        repeat (30) @(negedge clk);
        chk("arst_idle_slips", 32'(n_slip - base), 32'd0);
        chk("arst_idle_locked", 32'(bus.locked), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
